// File: rtl/tensor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : tensor_pkg                                                 |
// | Description : Shared sizing defaults and slot-state encoding for the     |
// |               tensor-op issue path (warp arbiter -> tensor controller).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tensor_pkg;

  // Default geometry of the issue path.
  localparam int TENSOR_NUM_WARPS = 4;
  localparam int TENSOR_WARP_ID_W = 2;
  localparam int TENSOR_REG_IDX_W = 4;

  // Transfer counter geometry.
  localparam int               ISSUE_CNT_W   = 16;
  localparam logic [15:0]      ISSUE_CNT_MAX = 16'hFFFF;

  // Single-entry request slot towards the tensor controller.
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : tensor_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Purely combinational round-robin picker. The search starts |
// |               one past last_grant, wraps modulo NUM_WARPS, and the first |
// |               requesting index wins.                                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   req        in  NUM_WARPS   requests eligible this cycle                |
// |   last_grant in  WARP_ID_W   index granted most recently                 |
// |   grant      out NUM_WARPS   one-hot winner (all-zero when none)         |
// |   grant_idx  out WARP_ID_W   binary index of the winner (0 when none)    |
// |   any        out 1           at least one request present                |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import tensor_pkg::*;
#(
  parameter int NUM_WARPS = TENSOR_NUM_WARPS,
  parameter int WARP_ID_W = TENSOR_WARP_ID_W
) (
  input  logic [NUM_WARPS-1:0] req,
  input  logic [WARP_ID_W-1:0] last_grant,
  output logic [NUM_WARPS-1:0] grant,
  output logic [WARP_ID_W-1:0] grant_idx,
  output logic                 any
);

  logic                 found;
  logic [WARP_ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    // Offsets 1..NUM_WARPS visit every index exactly once, ending on
    // last_grant itself, so a lone requester is always served again.
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = WARP_ID_W'((int'(last_grant) + i) % NUM_WARPS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
    any = found;
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/tensor_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tensor_issue_arbiter                                       |
// | Description : Arbitrates tensor-op requests from NUM_WARPS warps into a  |
// |               single registered request slot toward the tensor          |
// |               controller. Each warp may have at most one op in flight;  |
// |               completion pulses re-arm the warp.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk               in   1          rising-edge clock                    |
// |   reset             in   1          synchronous active-high reset        |
// |   enable            in   1          gate for new grants                  |
// |   warp_req_valid    in   NUM_WARPS  per-warp request                     |
// |   warp_req_dest     in   NxREG_IDX  per-warp destination register        |
// |   warp_req_ready    out  NUM_WARPS  one-hot grant pulse (combinational)  |
// |   tc_request_valid  out  1          slot holds a request                 |
// |   tc_warp_id        out  WARP_ID_W  warp of held request                 |
// |   tc_dest_reg_idx   out  REG_IDX_W  destination of held request          |
// |   tc_request_ready  in   1          controller accepts this cycle        |
// |   tc_warp_done      in   NUM_WARPS  completion pulses                    |
// |   warp_outstanding  out  NUM_WARPS  granted but not yet completed        |
// |   err_spurious_done out  1          sticky: done for idle warp           |
// |   issue_count       out  16         saturating transfer counter          |
// +--------------------------------------------------------------------------+
module tensor_issue_arbiter
  import tensor_pkg::*;
#(
  parameter int NUM_WARPS = TENSOR_NUM_WARPS,
  parameter int WARP_ID_W = TENSOR_WARP_ID_W,
  parameter int REG_IDX_W = TENSOR_REG_IDX_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [NUM_WARPS-1:0]                warp_req_valid,
  input  logic [NUM_WARPS-1:0][REG_IDX_W-1:0] warp_req_dest,
  output logic [NUM_WARPS-1:0]                warp_req_ready,
  output logic                                tc_request_valid,
  output logic [WARP_ID_W-1:0]                tc_warp_id,
  output logic [REG_IDX_W-1:0]                tc_dest_reg_idx,
  input  logic                                tc_request_ready,
  input  logic [NUM_WARPS-1:0]                tc_warp_done,
  output logic [NUM_WARPS-1:0]                warp_outstanding,
  output logic                                err_spurious_done,
  output logic [ISSUE_CNT_W-1:0]              issue_count
);

  // After reset the pointer sits on the last warp so warp 0 wins first.
  localparam logic [WARP_ID_W-1:0] LAST_GRANT_RST = WARP_ID_W'(NUM_WARPS - 1);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  slot_state_e            slot_q, slot_d;
  logic [WARP_ID_W-1:0]   warp_id_q, warp_id_d;
  logic [REG_IDX_W-1:0]   dest_q, dest_d;
  logic [WARP_ID_W-1:0]   last_grant_q, last_grant_d;
  logic [NUM_WARPS-1:0]   outstanding_q, outstanding_d;
  logic                   err_q, err_d;
  logic [ISSUE_CNT_W-1:0] issue_count_q, issue_count_d;

  // ---------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------
  logic                 transfer;
  logic                 can_load;
  logic                 grant_fire;
  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] arb_grant;
  logic [WARP_ID_W-1:0] arb_idx;
  logic                 arb_any;

  assign transfer = (slot_q == SLOT_FULL) && tc_request_ready;

  // A draining slot can be refilled in the same cycle, giving
  // back-to-back issue without a bubble.
  assign can_load = (slot_q == SLOT_EMPTY) || transfer;

  // A warp with an op still in flight is masked until its done pulse has
  // been registered, i.e. it re-arms one cycle after the done.
  assign eligible = warp_req_valid & ~outstanding_q & {NUM_WARPS{enable}};

  rr_arbiter #(
    .NUM_WARPS (NUM_WARPS),
    .WARP_ID_W (WARP_ID_W)
  ) u_rr_arbiter (
    .req        (eligible),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  // Reset suppresses the handshake so no warp believes it was accepted
  // during a cycle whose effects are about to be discarded.
  assign grant_fire     = can_load && arb_any && !reset;
  assign warp_req_ready = grant_fire ? arb_grant : '0;

  // ---------------------------------------------------------------------
  // Slot FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    slot_d = slot_q;
    unique case (slot_q)
      SLOT_EMPTY: begin
        if (grant_fire) slot_d = SLOT_FULL;
      end
      SLOT_FULL: begin
        if (transfer && !grant_fire) slot_d = SLOT_EMPTY;
      end
      default: slot_d = SLOT_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath / bookkeeping next state
  // ---------------------------------------------------------------------
  always_comb begin
    warp_id_d     = warp_id_q;
    dest_d        = dest_q;
    last_grant_d  = last_grant_q;
    outstanding_d = outstanding_q;
    err_d         = err_q;
    issue_count_d = issue_count_q;

    // Payload only changes on a load, so it is stable while FULL and
    // stalled, and also unaffected by enable.
    if (grant_fire) begin
      warp_id_d    = arb_idx;
      dest_d       = warp_req_dest[arb_idx];
      last_grant_d = arb_idx;
    end

    // Clearing and setting touch different bits except when a done hits
    // the warp being granted; that warp was idle, so the done is spurious
    // and the fresh grant correctly leaves the flag set.
    outstanding_d = (outstanding_q & ~tc_warp_done)
                  | (grant_fire ? arb_grant : '0);

    if (|(tc_warp_done & ~outstanding_q)) err_d = 1'b1;

    if (transfer && (issue_count_q != ISSUE_CNT_MAX)) begin
      issue_count_d = issue_count_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q        <= SLOT_EMPTY;
      warp_id_q     <= '0;
      dest_q        <= '0;
      last_grant_q  <= LAST_GRANT_RST;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      issue_count_q <= '0;
    end else begin
      slot_q        <= slot_d;
      warp_id_q     <= warp_id_d;
      dest_q        <= dest_d;
      last_grant_q  <= last_grant_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      issue_count_q <= issue_count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign tc_request_valid  = (slot_q == SLOT_FULL);
  assign tc_warp_id        = warp_id_q;
  assign tc_dest_reg_idx   = dest_q;
  assign warp_outstanding  = outstanding_q;
  assign err_spurious_done = err_q;
  assign issue_count       = issue_count_q;

endmodule : tensor_issue_arbiter
`default_nettype wire

// File: tb/tb_tensor_issue_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tensor_issue_arbiter                                    |
// | Description : Directed, table-driven bench for tensor_issue_arbiter.     |
// |               Inputs change on the falling edge; all outputs are        |
// |               sampled 1ns later, so registered outputs show the state   |
// |               before the next rising edge.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tensor_issue_arbiter;

  localparam int NUM_WARPS = 4;
  localparam int WARP_ID_W = 2;
  localparam int REG_IDX_W = 4;
  localparam int NV        = 17;

  logic                                clk;
  logic                                reset;
  logic                                enable;
  logic [NUM_WARPS-1:0]                warp_req_valid;
  logic [NUM_WARPS-1:0][REG_IDX_W-1:0] warp_req_dest;
  logic [NUM_WARPS-1:0]                warp_req_ready;
  logic                                tc_request_valid;
  logic [WARP_ID_W-1:0]                tc_warp_id;
  logic [REG_IDX_W-1:0]                tc_dest_reg_idx;
  logic                                tc_request_ready;
  logic [NUM_WARPS-1:0]                tc_warp_done;
  logic [NUM_WARPS-1:0]                warp_outstanding;
  logic                                err_spurious_done;
  logic [15:0]                         issue_count;

  tensor_issue_arbiter #(
    .NUM_WARPS (NUM_WARPS),
    .WARP_ID_W (WARP_ID_W),
    .REG_IDX_W (REG_IDX_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .warp_req_valid    (warp_req_valid),
    .warp_req_dest     (warp_req_dest),
    .warp_req_ready    (warp_req_ready),
    .tc_request_valid  (tc_request_valid),
    .tc_warp_id        (tc_warp_id),
    .tc_dest_reg_idx   (tc_dest_reg_idx),
    .tc_request_ready  (tc_request_ready),
    .tc_warp_done      (tc_warp_done),
    .warp_outstanding  (warp_outstanding),
    .err_spurious_done (err_spurious_done),
    .issue_count       (issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs, then the outputs expected during that cycle.
  typedef struct {
    logic        en;
    logic [3:0]  valid;
    logic        rdy;
    logic [3:0]  done;
    logic [3:0]  e_ready;
    logic        e_v;
    logic [1:0]  e_id;
    logic [3:0]  e_dest;
    logic [3:0]  e_out;
    logic        e_err;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [NV];

  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_row(input string tag, input vec_t v);
    check({tag, "_ready"}, 16'(warp_req_ready),    16'(v.e_ready));
    check({tag, "_valid"}, 16'(tc_request_valid),  16'(v.e_v));
    check({tag, "_id"},    16'(tc_warp_id),        16'(v.e_id));
    check({tag, "_dest"},  16'(tc_dest_reg_idx),   16'(v.e_dest));
    check({tag, "_out"},   16'(warp_outstanding),  16'(v.e_out));
    check({tag, "_err"},   16'(err_spurious_done), 16'(v.e_err));
    check({tag, "_cnt"},   issue_count,            v.e_cnt);
  endtask

  int  model_cnt;
  bit  pre_sat_seen;

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // Fixed destinations: warp w -> register w+5.
    warp_req_dest[0] = 4'd5;
    warp_req_dest[1] = 4'd6;
    warp_req_dest[2] = 4'd7;
    warp_req_dest[3] = 4'd8;

    //            en valid    rdy done     ready    v  id    dest  out      err cnt
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'd0, 4'b0000, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0010, 1'b1, 2'd0, 4'd5, 4'b0001, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd1, 4'd6, 4'b0011, 1'b0, 16'd1};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 2'd2, 4'd7, 4'b0111, 1'b0, 16'd2};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'd8, 4'b1111, 1'b0, 16'd3};
    // Done for w2; still masked in the same cycle.
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd3, 4'd8, 4'b1111, 1'b0, 16'd4};
    // w2 eligible one cycle after its done.
    vecs[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd3, 4'd8, 4'b1011, 1'b0, 16'd4};
    // Stall: slot held, w1 completes but cannot be granted.
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd2, 4'd7, 4'b1111, 1'b0, 16'd4};
    vecs[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'd7, 4'b1101, 1'b0, 16'd4};
    // Enable low: held request unchanged, drains, no new grant.
    vecs[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'd7, 4'b1101, 1'b0, 16'd4};
    vecs[10] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'd7, 4'b1101, 1'b0, 16'd4};
    // Done w0 and grant w1 in the same cycle.
    vecs[11] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 4'b0010, 1'b0, 2'd2, 4'd7, 4'b1101, 1'b0, 16'd5};
    vecs[12] = '{1'b1, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd1, 4'd6, 4'b1110, 1'b0, 16'd5};
    // Second done for w3 is spurious.
    vecs[13] = '{1'b1, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd1, 4'd6, 4'b0110, 1'b0, 16'd5};
    vecs[14] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'd6, 4'b0110, 1'b1, 16'd5};
    // Two dones in one cycle plus a grant of w3.
    vecs[15] = '{1'b1, 4'b1000, 1'b1, 4'b0110, 4'b1000, 1'b0, 2'd1, 4'd6, 4'b0110, 1'b1, 16'd6};
    vecs[16] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'd8, 4'b1000, 1'b1, 16'd6};

    // Reset with requests pending: no grant pulse may escape.
    reset            = 1'b1;
    enable           = 1'b1;
    warp_req_valid   = 4'b1111;
    tc_request_ready = 1'b1;
    tc_warp_done     = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst%0d_ready", i), 16'(warp_req_ready), 16'd0);
    end

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset            = 1'b0;
      enable           = vecs[i].en;
      warp_req_valid   = vecs[i].valid;
      tc_request_ready = vecs[i].rdy;
      tc_warp_done     = vecs[i].done;
      #1;
      check_row($sformatf("r%0d", i), vecs[i]);
    end

    // Reset while FULL with w3 outstanding and err set.
    @(negedge clk);
    reset            = 1'b1;
    enable           = 1'b1;
    warp_req_valid   = 4'b1111;
    tc_request_ready = 1'b1;
    tc_warp_done     = 4'b0000;
    #1;
    check("midrst_ready", 16'(warp_req_ready), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_valid", 16'(tc_request_valid),  16'd0);
    check("midrst_out",   16'(warp_outstanding),  16'd0);
    check("midrst_err",   16'(err_spurious_done), 16'd0);
    check("midrst_cnt",   issue_count,            16'd0);
    check("midrst_id",    16'(tc_warp_id),        16'd0);
    check("midrst_grant", 16'(warp_req_ready),    16'b0001);
    @(negedge clk);
    #1;
    check("post_rst_valid", 16'(tc_request_valid), 16'd1);
    check("post_rst_dest",  16'(tc_dest_reg_idx),  16'd5);

    // Saturation: keep transfers continuous by completing each warp as
    // soon as it is seen outstanding.
    model_cnt    = 1;  // the w0 load above transfers at the coming edge
    pre_sat_seen = 1'b0;
    for (int c = 0; c < 70000 && model_cnt < 65540; c++) begin
      @(negedge clk);
      tc_warp_done = warp_outstanding;
      #1;
      if (!pre_sat_seen && model_cnt == 65534) begin
        pre_sat_seen = 1'b1;
        check("cnt_pre_sat", issue_count, 16'd65534);
      end
      if (tc_request_valid && tc_request_ready) model_cnt++;
    end
    @(negedge clk);
    tc_warp_done = 4'b0000;
    #1;
    check("sat_budget", 16'(model_cnt >= 65540), 16'd1);
    check("cnt_sat",    issue_count,              16'hFFFF);
    check("sat_err",    16'(err_spurious_done),   16'd0);
    @(negedge clk);
    #1;
    check("cnt_sat_hold", issue_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_tensor_issue_arbiter
`default_nettype wire
